control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Hardwired control unit that drives the control inputs of the single-bus Datapath.
- Steps through instruction fetch (T0–T2), then decodes the IR value returned by the Datapath and sequences execute steps for register-register ALU instructions.
- Sits directly upstream of the Datapath and replaces hand-driven control strobes in system-level benches.

Parameters:
- OPW, 5, opcode field width (IR[31:27]).
- REGW, 4, register field width (Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15]).

Ports:
- Clock  in  1  system clock, rising-edge active.
- Clear  in  1  asynchronous active-low reset.
- IR  in  32  current IR contents from the Datapath.
- Stop  in  1  request to halt after the current instruction.
- PCout, Zlowout, MDRout, Rout  out  1 each  bus-drive enables.
- MARin, Zin, PCin, MDRin, IRin, Yin, Rin  out  1 each  register load enables.
- IncPC  out  1  ALU increments the bus value.
- Read  out  1  MDR takes memory data.
- Gra, Grb, Grc  out  1 each  select the Ra/Rb/Rc field for the Rin/Rout decode.
- alu_op  out  6  one-hot ALU strobe, bits 5..0 = NOT, NEG, OR, AND, SUB, ADD.
- Run  out  1  high while executing.
- Tstep  out  3  current step index, for debug.

Behaviour:
- Reset: Clear=0 forces state RST immediately, independent of Clock. All outputs are 0 while reset is held, including Run=0 and Tstep=0. This also applies if reset is asserted mid-instruction.
- Output style: Moore. Every output is a combinational function of the state register, plus IR[31:27] in T3–T5. Only the outputs listed for a state are 1; all others are 0.
- States: RST, T0, T1, T2, T3, T4, T5, HALTED. Transitions occur on the Clock rising edge.
- RST: the first edge after Clear deasserts moves to T0.
- T0: PCout, MARin, IncPC, Zin. Next state T1.
- T1: Zlowout, PCin, Read, MDRin. Next state T2.
- T2: MDRout, IRin. Next state T3. IR is valid from T3 onward.
- Opcode decode in T3–T5: ADD=00100, SUB=00101, AND=01010, OR=01011, NEG=10001, NOT=10010, NOP=11010, HALT=11011.
- Any other opcode executes as NOP.
- Three-operand ops (ADD, SUB, AND, OR):
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin, alu_op bit set.
  - T5: Zlowout, Gra, Rin.
  - Total 6 cycles per instruction.
- Two-operand ops (NEG, NOT):
  - T3: Grb, Rout, Zin, alu_op bit set.
  - T4: Zlowout, Gra, Rin.
  - Total 5 cycles per instruction.
- NOP: T3 asserts no strobes, then returns to T0. Total 4 cycles.
- HALT: T3 asserts no strobes, then moves to HALTED.
- Stop handling: Stop is sampled on every edge; a 1 sets an internal stop_req flag. stop_req is cleared only by reset.
- Instruction end: at the final step of any instruction, go to HALTED if stop_req is set (including Stop=1 on that same edge); otherwise go to T0.
- HALTED: all strobes 0, Run=0. State is held until reset.
- Run is 1 in T0–T5 and 0 in RST and HALTED.
- Tstep: T0..T5 = 0..5; RST and HALTED = 7.
- alu_op is at most one-hot, and nonzero only in its execute step.

Test Plan:
- Reset release: hold Clear=0 for 2 cycles, then release. Required: all outputs 0 and Run=0 during reset, RST for one cycle, then T0 with PCout=MARin=IncPC=Zin=1 and Tstep=0.
- NOT R5,R2 (IR=0x92900000 from T3):
  - T3: Grb=Rout=Zin=1, alu_op=6'b100000.
  - T4: Zlowout=Gra=Rin=1.
  - Next edge returns to T0; 5 cycles from T0 to T0.
- ADD R1,R2,R3 (IR=0x20918000):
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin, alu_op=6'b000001.
  - T5: Zlowout, Gra, Rin.
  - Then T0; 6 cycles.
- Stop pulsed one cycle during T4 of ADD: T5 completes normally, then HALTED with Run=0, all strobes 0 and Tstep=7, held for 10 cycles.
- HALT (IR=0xD8000000): after T3 enters HALTED. Illegal opcode (IR=0xF8000000): T3 with all strobes 0, then T0.
- Reset mid-op: Clear=0 asserted between edges during T4. All outputs go to 0 within the same cycle, then re-fetch starts at T0 after release.

Source files
------------

// File: rtl/control_sequencer.sv
// Hardwired control sequencer for the single-bus datapath: fetch in T0-T2,
// then decode IR[31:27] and sequence execute steps for register-register ALU ops.
module control_sequencer #(
    parameter int unsigned OPW  = 5,
    parameter int unsigned REGW = 4
) (
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] IR,
    input  logic        Stop,
    output logic        PCout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        Rout,
    output logic        MARin,
    output logic        Zin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Rin,
    output logic        IncPC,
    output logic        Read,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic [5:0]  alu_op,
    output logic        Run,
    output logic [2:0]  Tstep
);

    localparam logic [2:0] T0     = 3'd0;
    localparam logic [2:0] T1     = 3'd1;
    localparam logic [2:0] T2     = 3'd2;
    localparam logic [2:0] T3     = 3'd3;
    localparam logic [2:0] T4     = 3'd4;
    localparam logic [2:0] T5     = 3'd5;
    localparam logic [2:0] RST    = 3'd6;
    localparam logic [2:0] HALTED = 3'd7;

    localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00100);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00101);
    localparam logic [OPW-1:0] OP_AND  = OPW'(5'b01010);
    localparam logic [OPW-1:0] OP_OR   = OPW'(5'b01011);
    localparam logic [OPW-1:0] OP_NEG  = OPW'(5'b10001);
    localparam logic [OPW-1:0] OP_NOT  = OPW'(5'b10010);
    localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

    logic [2:0]     state;
    logic [2:0]     next_state;
    logic [2:0]     end_state;
    logic           stop_req;
    logic [OPW-1:0] opcode;
    logic           is_three_op;
    logic           is_two_op;
    logic           is_halt;
    logic [5:0]     alu_sel;

    // Register fields are consumed by the datapath's own Gra/Grb/Grc decode.
    logic [3*REGW-1:0]        unused_reg_fields;
    logic [31-OPW-3*REGW:0]   unused_ir_tail;
    assign unused_reg_fields = IR[31-OPW -: 3*REGW];
    assign unused_ir_tail    = IR[31-OPW-3*REGW:0];

    assign opcode = IR[31 -: OPW];

    always_comb begin
        alu_sel     = '0;
        is_three_op = 1'b0;
        is_two_op   = 1'b0;
        is_halt     = (opcode == OP_HALT);
        case (opcode)
            OP_ADD: begin alu_sel = 6'b000001; is_three_op = 1'b1; end
            OP_SUB: begin alu_sel = 6'b000010; is_three_op = 1'b1; end
            OP_AND: begin alu_sel = 6'b000100; is_three_op = 1'b1; end
            OP_OR:  begin alu_sel = 6'b001000; is_three_op = 1'b1; end
            OP_NEG: begin alu_sel = 6'b010000; is_two_op   = 1'b1; end
            OP_NOT: begin alu_sel = 6'b100000; is_two_op   = 1'b1; end
            default: ;
        endcase
    end

    // A Stop arriving on the final edge of an instruction still halts it.
    assign end_state = (stop_req || Stop) ? HALTED : T0;

    always_comb begin
        next_state = RST;
        case (state)
            RST:    next_state = T0;
            T0:     next_state = T1;
            T1:     next_state = T2;
            T2:     next_state = T3;
            T3:     next_state = is_halt ? HALTED :
                                 (is_three_op || is_two_op) ? T4 : end_state;
            T4:     next_state = is_three_op ? T5 : end_state;
            T5:     next_state = end_state;
            HALTED: next_state = HALTED;
            default: next_state = RST;
        endcase
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state    <= RST;
            stop_req <= 1'b0;
        end else begin
            state    <= next_state;
            stop_req <= stop_req | Stop;
        end
    end

    always_comb begin
        {PCout, Zlowout, MDRout, Rout, MARin, Zin, PCin, MDRin} = '0;
        {IRin, Yin, Rin, IncPC, Read, Gra, Grb, Grc}            = '0;
        alu_op = '0;
        Run    = 1'b0;
        Tstep  = '0;
        // Outputs are gated by Clear so they are all 0 while reset is held.
        if (Clear) begin
            Run   = (state != RST) && (state != HALTED);
            Tstep = Run ? state : 3'd7;
            case (state)
                T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
                T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
                T2: begin MDRout = 1'b1; IRin = 1'b1; end
                T3: begin
                    if (is_three_op) begin
                        Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                    end else if (is_two_op) begin
                        Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = alu_sel;
                    end
                end
                T4: begin
                    if (is_three_op) begin
                        Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = alu_sel;
                    end else if (is_two_op) begin
                        Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end
                end
                T5: begin
                    if (is_three_op) begin
                        Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: fetch/execute step sequences, Stop,
// HALT, illegal opcode and asynchronous reset, against hand-computed vectors.
module tb_control_sequencer;

    logic        Clock = 1'b0;
    logic        Clear = 1'b0;
    logic [31:0] IR    = '0;
    logic        Stop  = 1'b0;
    logic PCout, Zlowout, MDRout, Rout, MARin, Zin, PCin, MDRin;
    logic IRin, Yin, Rin, IncPC, Read, Gra, Grb, Grc, Run;
    logic [5:0] alu_op;
    logic [2:0] Tstep;

    int unsigned vecs = 0;
    int unsigned errs = 0;

    control_sequencer #(.OPW(5), .REGW(4)) dut (
        .Clock(Clock), .Clear(Clear), .IR(IR), .Stop(Stop),
        .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .Rout(Rout),
        .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
        .Yin(Yin), .Rin(Rin), .IncPC(IncPC), .Read(Read),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .alu_op(alu_op), .Run(Run), .Tstep(Tstep)
    );

    always #5 Clock = ~Clock;

    // Observed vector: 16 strobes, alu_op, Run, Tstep.
    logic [25:0] obs;
    assign obs = {PCout, Zlowout, MDRout, Rout, MARin, Zin, PCin, MDRin,
                  IRin, Yin, Rin, IncPC, Read, Gra, Grb, Grc, alu_op, Run, Tstep};

    function automatic logic [25:0] mk(input logic [15:0] s, input logic [5:0] a,
                                       input logic r, input logic [2:0] t);
        return {s, a, r, t};
    endfunction

    localparam logic [31:0] IR_NOT  = 32'h9290_0000;
    localparam logic [31:0] IR_ADD  = 32'h2091_8000;
    localparam logic [31:0] IR_HALT = 32'hD800_0000;
    localparam logic [31:0] IR_ILL  = 32'hF800_0000;

    logic [25:0] E_ZERO, E_IDLE, E_T0, E_T1, E_T2, E_NOT3, E_WB4, E_ADD3, E_ADD4, E_WB5, E_NOP3;

    initial begin
        E_ZERO = '0;
        E_IDLE = mk(16'h0000, 6'b000000, 1'b0, 3'd7);
        E_T0   = mk(16'h8C10, 6'b000000, 1'b1, 3'd0);
        E_T1   = mk(16'h4308, 6'b000000, 1'b1, 3'd1);
        E_T2   = mk(16'h2080, 6'b000000, 1'b1, 3'd2);
        E_NOT3 = mk(16'h1402, 6'b100000, 1'b1, 3'd3);
        E_WB4  = mk(16'h4024, 6'b000000, 1'b1, 3'd4);
        E_ADD3 = mk(16'h1042, 6'b000000, 1'b1, 3'd3);
        E_ADD4 = mk(16'h1401, 6'b000001, 1'b1, 3'd4);
        E_WB5  = mk(16'h4024, 6'b000000, 1'b1, 3'd5);
        E_NOP3 = mk(16'h0000, 6'b000000, 1'b1, 3'd3);
    end

    task automatic test_reset();
        for (int unsigned i = 0; i < 2; i++) begin
            @(negedge Clock);
            vecs++;
            if (obs !== E_ZERO) begin
                $display("FAIL reset_held[%0d] got %h want %h", i, obs, E_ZERO); errs++;
            end
        end
        Clear = 1'b1;
        #1;
        vecs++;
        if (obs !== E_IDLE) begin
            $display("FAIL reset_rst_state got %h want %h", obs, E_IDLE); errs++;
        end
        @(negedge Clock);
        vecs++;
        if (obs !== E_T0) begin
            $display("FAIL reset_t0 got %h want %h", obs, E_T0); errs++;
        end
    endtask

    task automatic test_not();
        logic [25:0] exp [5];
        exp = '{E_T1, E_T2, E_NOT3, E_WB4, E_T0};
        IR = IR_NOT;
        for (int unsigned i = 0; i < 5; i++) begin
            @(negedge Clock);
            vecs++;
            if (obs !== exp[i]) begin
                $display("FAIL not_step[%0d] got %h want %h", i, obs, exp[i]); errs++;
            end
        end
    endtask

    task automatic test_add();
        logic [25:0] exp [6];
        exp = '{E_T1, E_T2, E_ADD3, E_ADD4, E_WB5, E_T0};
        IR = IR_ADD;
        for (int unsigned i = 0; i < 6; i++) begin
            @(negedge Clock);
            vecs++;
            if (obs !== exp[i]) begin
                $display("FAIL add_step[%0d] got %h want %h", i, obs, exp[i]); errs++;
            end
        end
    endtask

    task automatic test_illegal();
        logic [25:0] exp [4];
        exp = '{E_T1, E_T2, E_NOP3, E_T0};
        IR = IR_ILL;
        for (int unsigned i = 0; i < 4; i++) begin
            @(negedge Clock);
            vecs++;
            if (obs !== exp[i]) begin
                $display("FAIL illegal_step[%0d] got %h want %h", i, obs, exp[i]); errs++;
            end
        end
    endtask

    task automatic test_halt();
        logic [25:0] exp [6];
        exp = '{E_T1, E_T2, E_NOP3, E_IDLE, E_IDLE, E_IDLE};
        IR = IR_HALT;
        for (int unsigned i = 0; i < 6; i++) begin
            @(negedge Clock);
            vecs++;
            if (obs !== exp[i]) begin
                $display("FAIL halt_step[%0d] got %h want %h", i, obs, exp[i]); errs++;
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [25:0] exp [4];
        exp = '{E_T0, E_T1, E_T2, E_ADD3};
        // Leave HALTED through a reset, then interrupt an ADD in T4.
        Clear = 1'b0;
        @(negedge Clock);
        Clear = 1'b1;
        IR = IR_ADD;
        for (int unsigned i = 0; i < 4; i++) begin
            @(negedge Clock);
            vecs++;
            if (obs !== exp[i]) begin
                $display("FAIL rmid_fetch[%0d] got %h want %h", i, obs, exp[i]); errs++;
            end
        end
        @(negedge Clock);
        vecs++;
        if (obs !== E_ADD4) begin
            $display("FAIL rmid_t4 got %h want %h", obs, E_ADD4); errs++;
        end
        #2 Clear = 1'b0;
        #1;
        vecs++;
        if (obs !== E_ZERO) begin
            $display("FAIL rmid_async got %h want %h", obs, E_ZERO); errs++;
        end
        @(negedge Clock);
        vecs++;
        if (obs !== E_ZERO) begin
            $display("FAIL rmid_held got %h want %h", obs, E_ZERO); errs++;
        end
        Clear = 1'b1;
        #1;
        vecs++;
        if (obs !== E_IDLE) begin
            $display("FAIL rmid_rst got %h want %h", obs, E_IDLE); errs++;
        end
        @(negedge Clock);
        vecs++;
        if (obs !== E_T0) begin
            $display("FAIL rmid_refetch got %h want %h", obs, E_T0); errs++;
        end
    endtask

    task automatic test_stop();
        logic [25:0] exp [4];
        exp = '{E_T1, E_T2, E_ADD3, E_ADD4};
        IR = IR_ADD;
        for (int unsigned i = 0; i < 4; i++) begin
            @(negedge Clock);
            vecs++;
            if (obs !== exp[i]) begin
                $display("FAIL stop_pre[%0d] got %h want %h", i, obs, exp[i]); errs++;
            end
        end
        Stop = 1'b1;
        @(negedge Clock);
        Stop = 1'b0;
        vecs++;
        if (obs !== E_WB5) begin
            $display("FAIL stop_t5 got %h want %h", obs, E_WB5); errs++;
        end
        for (int unsigned i = 0; i < 11; i++) begin
            @(negedge Clock);
            vecs++;
            if (obs !== E_IDLE) begin
                $display("FAIL stop_halted[%0d] got %h want %h", i, obs, E_IDLE); errs++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_not();
        test_add();
        test_illegal();
        test_halt();
        test_reset_mid();
        test_stop();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
